// File: rtl/puf_soc_pkg.sv
// Shared types and defaults for the PUF ring-oscillator sampler.
package puf_soc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COUNT,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } state_e;

  localparam int WINDOW_DEF = 1024;
  localparam int SETTLE_DEF = 2;

endpackage

// File: rtl/puf_soc_ro_cmp.sv
// Registered count comparator producing one response bit plus tie/err flags.
module puf_soc_ro_cmp #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_cnt_a,
  input  logic [W-1:0] i_cnt_b,
  input  logic         i_full_a,
  input  logic         i_full_b,
  output logic         o_gt,
  output logic         o_tie,
  output logic         o_err
);

  logic gt_d, gt_q;
  logic tie_d, tie_q;
  logic err_d, err_q;

  always_comb begin
    gt_d  = i_cnt_a > i_cnt_b;
    tie_d = i_cnt_a == i_cnt_b;
    err_d = i_full_a | i_full_b;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gt_q  <= 1'b0;
      tie_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      gt_q  <= gt_d;
      tie_q <= tie_d;
      err_q <= err_d;
    end
  end

  assign o_gt  = gt_q;
  assign o_tie = tie_q;
  assign o_err = err_q;

endmodule

// File: rtl/puf_soc_ro_sampler.sv
// Sequences clear/count/settle/compare over RESP_BITS oscillator pairs
// and hands the assembled response word out on a valid/ready handshake.
module puf_soc_ro_sampler
  import puf_soc_pkg::*;
#(
  parameter int CNT_BIT_SIZE = 32,
  parameter int WINDOW       = WINDOW_DEF,
  parameter int SETTLE       = SETTLE_DEF,
  parameter int RESP_BITS    = 16,
  parameter int SEL_W        = $clog2(RESP_BITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_cnt_clr_n,
  output logic                    o_cnt_en,
  output logic [SEL_W-1:0]        o_sel,
  input  logic [CNT_BIT_SIZE-1:0] i_cnt_a,
  input  logic [CNT_BIT_SIZE-1:0] i_cnt_b,
  input  logic                    i_full_a,
  input  logic                    i_full_b,
  output logic [RESP_BITS-1:0]    o_resp,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic                    o_tie,
  output logic                    o_err
);

  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e state_d, state_q;
  logic [TMR_W-1:0]     tmr_d, tmr_q;
  logic [SEL_W-1:0]     idx_d, idx_q;
  logic [SEL_W-1:0]     sel_d, sel_q;
  logic [RESP_BITS-1:0] resp_d, resp_q;
  logic busy_d, busy_q;
  logic clr_n_d, clr_n_q;
  logic en_d, en_q;
  logic valid_d, valid_q;
  logic tie_d, tie_q;
  logic err_d, err_q;
  logic cmp_gt, cmp_tie, cmp_err;

  // Comparator samples every cycle; counts are stable through SETTLE.
  puf_soc_ro_cmp #(
    .W(CNT_BIT_SIZE)
  ) u_cmp (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_cnt_a (i_cnt_a),
    .i_cnt_b (i_cnt_b),
    .i_full_a(i_full_a),
    .i_full_b(i_full_b),
    .o_gt    (cmp_gt),
    .o_tie   (cmp_tie),
    .o_err   (cmp_err)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    resp_d  = resp_q;
    busy_d  = busy_q;
    clr_n_d = clr_n_q;
    en_d    = en_q;
    valid_d = valid_q;
    tie_d   = tie_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
          clr_n_d = 1'b0;
          sel_d   = '0;
          idx_d   = '0;
          resp_d  = '0;
          tie_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_CLEAR: begin
        state_d = ST_COUNT;
        clr_n_d = 1'b1;
        en_d    = 1'b1;
        tmr_d   = '0;
      end
      ST_COUNT: begin
        if (tmr_q == TMR_W'(WINDOW - 1)) begin
          state_d = ST_SETTLE;
          en_d    = 1'b0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == TMR_W'(SETTLE - 1)) begin
          state_d = ST_COMPARE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_COMPARE: begin
        resp_d[idx_q] = cmp_gt;
        tie_d = tie_q | cmp_tie;
        err_d = err_q | cmp_err;
        if (idx_q == SEL_W'(RESP_BITS - 1)) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
        end else begin
          state_d = ST_CLEAR;
          clr_n_d = 1'b0;
          idx_d   = idx_q + 1'b1;
          sel_d   = sel_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (i_resp_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      resp_q  <= '0;
      busy_q  <= 1'b0;
      clr_n_q <= 1'b1;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      tie_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      clr_n_q <= clr_n_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      tie_q   <= tie_d;
      err_q   <= err_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_cnt_clr_n  = clr_n_q;
  assign o_cnt_en     = en_q;
  assign o_sel        = sel_q;
  assign o_resp       = resp_q;
  assign o_resp_valid = valid_q;
  assign o_tie        = tie_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_puf_soc_ro_sampler.sv
// Randomized bench for puf_soc_ro_sampler with two modelled counters.
module tb_puf_soc_ro_sampler;

  localparam int CW  = 8;
  localparam int WIN = 8;
  localparam int SET = 2;
  localparam int RB  = 4;
  localparam int SW  = 2;
  localparam int LAT = RB * (2 + WIN + SET);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic i_resp_ready = 1'b0;
  logic o_busy, o_cnt_clr_n, o_cnt_en, o_resp_valid, o_tie, o_err;
  logic [SW-1:0] o_sel;
  logic [RB-1:0] o_resp;
  logic [CW-1:0] cnt_a, cnt_b;
  logic full_a, full_b;

  int checks = 0;
  int failures = 0;
  int rate_a [RB];
  int rate_b [RB];
  int ph_a, ph_b;
  bit force_full;

  always #5 clk = ~clk;

  puf_soc_ro_sampler #(
    .CNT_BIT_SIZE(CW),
    .WINDOW      (WIN),
    .SETTLE      (SET),
    .RESP_BITS   (RB),
    .SEL_W       (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_cnt_clr_n (o_cnt_clr_n),
    .o_cnt_en    (o_cnt_en),
    .o_sel       (o_sel),
    .i_cnt_a     (cnt_a),
    .i_cnt_b     (cnt_b),
    .i_full_a    (full_a),
    .i_full_b    (full_b),
    .o_resp      (o_resp),
    .o_resp_valid(o_resp_valid),
    .i_resp_ready(i_resp_ready),
    .o_tie       (o_tie),
    .o_err       (o_err)
  );

  // Counter pair: each increments once every rate enabled cycles.
  always @(posedge clk) begin
    if (!o_cnt_clr_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
      ph_a  <= 0;
      ph_b  <= 0;
    end else if (o_cnt_en) begin
      if (ph_a == rate_a[o_sel] - 1) begin
        ph_a <= 0;
        if (cnt_a != 8'hff) cnt_a <= cnt_a + 1'b1;
      end else ph_a <= ph_a + 1;
      if (ph_b == rate_b[o_sel] - 1) begin
        ph_b <= 0;
        if (cnt_b != 8'hff) cnt_b <= cnt_b + 1'b1;
      end else ph_b <= ph_b + 1;
    end
  end

  assign full_a = (cnt_a == 8'hff);
  assign full_b = (cnt_b == 8'hff) || (force_full && o_sel == 2'd1);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected word from counts implied by the rates over one window.
  task automatic model(output logic [RB-1:0] resp, output logic tie,
                       output logic err);
    int na, nb;
    resp = '0;
    tie  = 1'b0;
    err  = force_full;
    for (int i = 0; i < RB; i++) begin
      na = WIN / rate_a[i];
      nb = WIN / rate_b[i];
      resp[i] = na > nb;
      if (na == nb) tie = 1'b1;
    end
  endtask

  task automatic run(input string tag, input bit hold);
    logic [RB-1:0] er;
    logic et, ee;
    int n, clr_cnt;
    logic [SW-1:0] sels [$];
    model(er, et, ee);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    clr_cnt = 0;
    while (!o_resp_valid && n < 200) begin
      if (!o_cnt_clr_n) begin
        clr_cnt++;
        sels.push_back(o_sel);
      end
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, LAT);
    chk({tag, "_clr"}, clr_cnt, RB);
    for (int i = 0; i < sels.size(); i++)
      chk({tag, "_sel"}, sels[i], i);
    chk({tag, "_resp"}, o_resp, er);
    chk({tag, "_tie"}, o_tie, et);
    chk({tag, "_err"}, o_err, ee);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        i_start = (i % 2 == 0);
        tick();
        chk({tag, "_hold_v"}, o_resp_valid, 1);
        chk({tag, "_hold_r"}, o_resp, er);
        chk({tag, "_hold_b"}, o_busy, 1);
      end
      i_start = 1'b1;
    end
    i_resp_ready = 1'b1;
    tick();
    i_resp_ready = 1'b0;
    i_start = 1'b0;
    chk({tag, "_rel_v"}, o_resp_valid, 0);
    chk({tag, "_rel_b"}, o_busy, 0);
    tick();
    chk({tag, "_idle_b"}, o_busy, 0);
    chk({tag, "_idle_r"}, o_resp, er);
  endtask

  task automatic set_rates(input int a0, input int b0, input int a1,
                           input int b1);
    for (int i = 0; i < RB; i++) begin
      rate_a[i] = (i % 2 == 0) ? a0 : a1;
      rate_b[i] = (i % 2 == 0) ? b0 : b1;
    end
  endtask

  initial begin
    int n, vseen;
    force_full = 1'b0;
    set_rates(1, 2, 1, 2);
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_busy", o_busy, 0);
    chk("rst_clr", o_cnt_clr_n, 1);
    chk("rst_en", o_cnt_en, 0);
    chk("rst_sel", o_sel, 0);
    chk("rst_resp", o_resp, 0);
    chk("rst_valid", o_resp_valid, 0);
    chk("rst_tie", o_tie, 0);
    chk("rst_err", o_err, 0);
    tick();

    run("fast_a", 1'b0);
    set_rates(1, 2, 2, 1);
    run("alt", 1'b0);
    set_rates(1, 1, 1, 1);
    run("equal", 1'b0);
    set_rates(1, 2, 1, 2);
    force_full = 1'b1;
    run("full", 1'b0);
    force_full = 1'b0;
    set_rates(2, 1, 1, 2);
    run("hold", 1'b1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < RB; i++) begin
        rate_a[i] = $urandom_range(1, 4);
        rate_b[i] = $urandom_range(1, 4);
      end
      force_full = ($urandom_range(0, 3) == 0);
      run("rnd", ($urandom_range(0, 1) == 1));
      force_full = 1'b0;
    end

    set_rates(1, 2, 1, 2);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (!(o_sel == 2'd2 && o_cnt_en) && n < 200) begin
      tick();
      n++;
    end
    chk("mid_reach", (n < 200), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_busy", o_busy, 0);
    chk("mid_clr", o_cnt_clr_n, 1);
    chk("mid_en", o_cnt_en, 0);
    chk("mid_sel", o_sel, 0);
    chk("mid_resp", o_resp, 0);
    chk("mid_valid", o_resp_valid, 0);
    chk("mid_tie", o_tie, 0);
    chk("mid_err", o_err, 0);
    vseen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (o_resp_valid || o_busy) vseen++;
    end
    chk("mid_quiet", vseen, 0);

    run("after", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
